// File: rtl/key_settle_fsm_if.sv
// Edge-pulse inputs and debounced key outputs of key_settle_fsm.
// master drives the edge pulses and pin level; slave is the settle FSM.
interface key_settle_fsm_if;
  logic H2L_Sig;
  logic L2H_Sig;
  logic Pin_in;
  logic Key_out;
  logic Press_Sig;
  logic Release_Sig;
  logic Busy;
  logic Long_Sig;

  modport master (
    output H2L_Sig, L2H_Sig, Pin_in,
    input  Key_out, Press_Sig, Release_Sig, Busy, Long_Sig
  );

  modport slave (
    input  H2L_Sig, L2H_Sig, Pin_in,
    output Key_out, Press_Sig, Release_Sig, Busy, Long_Sig
  );
endinterface

// File: rtl/key_settle_fsm.sv
// Key settle FSM: holds off each edge pulse for T_SETTLE cycles and commits a new
// key level only if the pin still agrees. Optional long-press strobe via KEY_LONGPRESS_EN.
module key_settle_fsm #(
  parameter logic [23:0] T_SETTLE = 24'd120000,
  parameter logic [23:0] T_LONG   = 24'd12000000
) (
  input  logic             Sys_clk,
  input  logic             Sys_reset,
  key_settle_fsm_if.slave  key_bus
);

  localparam int unsigned CNT_W = 24;

  typedef enum logic [1:0] {
    IDLE_HI   = 2'd0,
    WAIT_LO   = 2'd1,
    LO_STABLE = 2'd2,
    WAIT_HI   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q, key_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] cnt_inc_c;
  logic             edge_c;
  logic             expire_c;

  // The window ends on the cycle the counter reaches T_SETTLE-1, so the
  // registered strobe lands exactly T_SETTLE cycles after the last edge pulse.
  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign edge_c    = key_bus.H2L_Sig | key_bus.L2H_Sig;
  assign expire_c  = (cnt_inc_c == (T_SETTLE - CNT_W'(1)));

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    busy_d    = 1'b0;

    case (state_q)
      IDLE_HI: begin
        key_d = 1'b1;
        if (key_bus.H2L_Sig && !key_bus.L2H_Sig) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      WAIT_LO: begin
        busy_d = 1'b1;
        if (edge_c) begin
          cnt_d = '0;
        end else if (expire_c) begin
          cnt_d = '0;
          if (!key_bus.Pin_in) begin
            state_d = LO_STABLE;
            key_d   = 1'b0;
            press_d = 1'b1;
          end else begin
            state_d = IDLE_HI;
          end
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      LO_STABLE: begin
        key_d = 1'b0;
        if (key_bus.L2H_Sig && !key_bus.H2L_Sig) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      WAIT_HI: begin
        busy_d = 1'b1;
        if (edge_c) begin
          cnt_d = '0;
        end else if (expire_c) begin
          cnt_d = '0;
          if (key_bus.Pin_in) begin
            state_d   = IDLE_HI;
            key_d     = 1'b1;
            release_d = 1'b1;
          end else begin
            state_d = LO_STABLE;
          end
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      default: begin
        state_d = IDLE_HI;
        cnt_d   = '0;
        key_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Sys_clk or posedge Sys_reset) begin
    if (Sys_reset) begin
      state_q   <= IDLE_HI;
      cnt_q     <= '0;
      key_q     <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      press_q   <= press_d;
      release_q <= release_d;
      busy_q    <= busy_d;
    end
  end

  assign key_bus.Key_out     = key_q;
  assign key_bus.Press_Sig   = press_q;
  assign key_bus.Release_Sig = release_q;
  assign key_bus.Busy        = busy_q;

`ifdef KEY_LONGPRESS_EN
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  // Hold timer: runs in LO_STABLE, frozen across a release window, stops at T_LONG
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;

    case (state_q)
      LO_STABLE: begin
        if (hold_q < T_LONG) begin
          hold_d = hold_q + CNT_W'(1);
          long_d = (hold_q == (T_LONG - CNT_W'(1)));
        end
      end
      WAIT_HI: hold_d = hold_q;
      default: hold_d = '0;
    endcase

    if ((state_q == WAIT_LO) && (state_d == LO_STABLE)) begin
      hold_d = '0;
    end
    if ((state_q == WAIT_HI) && (state_d == IDLE_HI)) begin
      hold_d = '0;
    end
  end

  always_ff @(posedge Sys_clk or posedge Sys_reset) begin
    if (Sys_reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign key_bus.Long_Sig = long_q;
`else
  assign key_bus.Long_Sig = 1'b0;
`endif

endmodule
